// File: rtl/fadd_pkg.sv
// rtl/fadd_pkg.sv - shared types, widths and helpers for the fadd_sched slice
package fadd_pkg;

    localparam int FP16_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index width for n requesters, never narrower than one bit
    function automatic int id_width(input int n);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= n) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/fadd_sched_if.sv
// rtl/fadd_sched_if.sv - requester and response bundle between clients and fadd_sched
interface fadd_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [15:0]        rsp_data;
    logic [IDW-1:0]     rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/f_adder.sv
// rtl/f_adder.sv - combinational FP16 adder, truncating, no special-value handling
module f_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic [15:0] x, z;
    logic [4:0]  ex, ez, d;
    logic [5:0]  e;
    logic [14:0] mx, mz, s;

    // Align the smaller magnitude to the larger, add or subtract, renormalise
    always_comb begin
        if (a[14:0] >= b[14:0]) begin
            x = a;
            z = b;
        end else begin
            x = b;
            z = a;
        end
        ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ez = (z[14:10] == 5'd0) ? 5'd1 : z[14:10];
        mx = {1'b0, x[14:10] != 5'd0, x[9:0], 3'b000};
        mz = {1'b0, z[14:10] != 5'd0, z[9:0], 3'b000};
        d  = ex - ez;
        mz = (d > 5'd14) ? 15'd0 : (mz >> d);
        e  = {1'b0, ex};
        if (x[15] == z[15]) s = mx + mz;
        else                s = mx - mz;
        if (s[14]) begin
            s = s >> 1;
            e = e + 6'd1;
        end
        for (int i = 0; i < 13; i++) begin
            if (!s[13] && (e > 6'd1) && (s != 15'd0)) begin
                s = s << 1;
                e = e - 6'd1;
            end
        end
        if (s == 15'd0)       y = 16'h0000;
        else if (e >= 6'd31)  y = {x[15], 5'h1F, 10'h000};
        else if (!s[13])      y = {x[15], 5'd0, s[12:3]};
        else                  y = {x[15], e[4:0], s[12:3]};
    end
endmodule

// File: rtl/fadd_sched_rr_arbiter.sv
// rtl/fadd_sched_rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);
    logic           found;
    logic [IDW-1:0] j;

    // First valid index scanning ptr, ptr+1, ... modulo NREQ
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = IDW'((int'(ptr) + k) % NREQ);
            if (en && !found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end
endmodule

// File: rtl/fadd_sched.sv
// rtl/fadd_sched.sv - round-robin scheduler over one shared f_adder; FADD_SCHED_STATS_EN adds op_count
module fadd_sched
    import fadd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FADD_SCHED_STATS_EN
    output logic [15:0] op_count,
`endif
    fadd_sched_if.slave bus
);
    state_t              state;
    logic [IDW-1:0]      ptr, id_q, gidx, rsp_id_q;
    logic [FP16_W-1:0]   opa, opb, sum, rsp_data_q;
    logic                rsp_valid_q;
    logic [NREQ-1:0]     grant;
    logic                arb_en;

    // Grants are only offered while idle and out of reset
    assign arb_en = (state == IDLE) && !rst;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (grant),
        .idx   (gidx)
    );

    f_adder u_add (
        .a (opa),
        .b (opb),
        .y (sum)
    );

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

    // Accept -> add -> hold result until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            id_q        <= '0;
            opa         <= '0;
            opb         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        opa   <= bus.req_a[FP16_W*gidx +: FP16_W];
                        opb   <= bus.req_b[FP16_W*gidx +: FP16_W];
                        id_q  <= gidx;
                        ptr   <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= sum;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FADD_SCHED_STATS_EN
    logic [15:0] op_cnt_q;

    // Completed-response counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst)                                op_cnt_q <= '0;
        else if (rsp_valid_q && bus.rsp_ready)  op_cnt_q <= op_cnt_q + 16'd1;
    end

    assign op_count = op_cnt_q;
`endif
endmodule

// File: tb/tb_fadd_sched.sv
// tb/tb_fadd_sched.sv - self-checking bench for fadd_sched with a behavioural scheduler model
module tb_fadd_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fadd_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef FADD_SCHED_STATS_EN
    logic [15:0] op_count;
    fadd_sched #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .op_count(op_count), .bus(bus));
`else
    fadd_sched #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // FP16 value semantics as plain reals
    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) m = real'(h[9:0]) * (2.0 ** (-24));
        else        m = real'(1024 + int'(h[9:0])) * (2.0 ** (e - 25));
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r_in);
        real  r, m;
        int   e;
        logic s;
        r = r_in;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        if (s) r = -r;
        e = 15;
        m = r / (2.0 ** 0);
        m = r / 1.0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > 1) begin m = m * 2.0; e--; end
        if (e >= 31) return {s, 5'h1F, 10'h000};
        if (m < 1.0) return {s, 5'd0, 10'($rtoi(m * 1024.0))};
        return {s, 5'(e), 10'($rtoi((m - 1.0) * 1024.0))};
    endfunction

    // Model state: pending expected response, rotating priority start, logs
    logic [15:0] exp_data;
    int          exp_id;
    bit          pend = 0;
    int          acc_cyc = 0;
    int          mptr = 0;
    int          glog[$];
    int          rlog_id[$];
    logic [15:0] rlog_data[$];

    // One compare process, every cycle away from the active edge
    always @(negedge clk) begin
        int g, j;
        bit exp_v;
        logic [15:0] a, b;
        if (rst) begin
            chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
            pend = 0;
            mptr = 0;
        end else begin
            exp_v = pend && (cyc >= acc_cyc + 2);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
            if (pend) begin
                chk("ready_busy", 32'(bus.req_ready), 32'd0);
            end else begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    j = (mptr + k) % NREQ;
                    if (g < 0 && bus.req_valid[j]) g = j;
                end
                chk("grant", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            end
            if (exp_v && bus.rsp_valid) begin
                chk("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
                chk("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
                if (bus.rsp_ready) begin
                    rlog_id.push_back(int'(bus.rsp_id));
                    rlog_data.push_back(bus.rsp_data);
                    pend = 0;
                end
            end else if (!pend && |(bus.req_valid & bus.req_ready)) begin
                g = -1;
                for (int k = 0; k < NREQ; k++) if (bus.req_ready[k] && g < 0) g = k;
                a = bus.req_a[16*g +: 16];
                b = bus.req_b[16*g +: 16];
                exp_data = r2h(h2r(a) + h2r(b));
                exp_id   = g;
                pend     = 1;
                acc_cyc  = cyc;
                mptr     = (g + 1) % NREQ;
                glog.push_back(g);
            end
        end
    end

    task automatic send(input int i, input logic [15:0] a, input logic [15:0] b);
        bit acc;
        acc = 0;
        bus.req_a[16*i +: 16] = a;
        bus.req_b[16*i +: 16] = b;
        bus.req_valid[i] = 1'b1;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = bus.req_valid[i] && bus.req_ready[i];
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (pend || bus.rsp_valid); k++) @(negedge clk);
        chk("drain_idle", 32'(pend || bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int base, rbase;
        int e2[5] = '{0, 1, 2, 3, 2};
        bus.req_valid = '1;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;

        // Model pins
        chk("model_1p2", 32'(r2h(h2r(16'h3C00) + h2r(16'h4000))), 32'h4200);
        chk("model_4p3", 32'(r2h(h2r(16'h4400) + h2r(16'h4200))), 32'h4700);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        @(posedge clk);
        #1;

        // Single request, two-cycle latency
        send(0, 16'h3C00, 16'h4000);
        @(negedge clk);
        chk("t1_exec_no_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_data", 32'(bus.rsp_data), 32'h4200);
        chk("t1_id", 32'(bus.rsp_id), 32'd0);
        drain();

        // All four at once, then a req2 re-request
        do_reset();
        base = glog.size();
        rbase = rlog_id.size();
        fork
            send(0, 16'h3C00, 16'h3C00);
            send(1, 16'h4000, 16'hBC00);
            begin send(2, 16'h4400, 16'h4200); send(2, 16'h3800, 16'hB800); end
            send(3, 16'h3C00, 16'h4000);
        join
        drain();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_grant%0d", k), 32'(glog[base+k]), 32'(e2[k]));
            chk($sformatf("t2_rspid%0d", k), 32'(rlog_id[rbase+k]), 32'(e2[k]));
        end
        chk("t2_sum2", 32'(rlog_data[rbase+2]), 32'h4700);
        chk("t2_sum_zero", 32'(rlog_data[rbase+4]), 32'h0000);

        // Backpressure for 10 cycles
        bus.rsp_ready = 1'b0;
        fork
            begin
                send(1, 16'h3800, 16'h3E00);
                @(negedge clk);
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
                    chk("bp_data", 32'(bus.rsp_data), 32'h4000);
                    chk("bp_ready", 32'(bus.req_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                bus.rsp_ready = 1'b1;
            end
            begin
                @(posedge clk);
                #1;
                send(0, 16'h3C00, 16'h3C00);
            end
        join
        drain();

        // Fairness between 0 and 3
        do_reset();
        base = glog.size();
        fork
            for (int k = 0; k < 4; k++) send(0, 16'h3C00, 16'h3C00);
            for (int k = 0; k < 4; k++) send(3, 16'h3C00, 16'h3C00);
        join
        drain();
        for (int k = 0; k < 8; k++)
            chk($sformatf("fair%0d", k), 32'(glog[base+k]), (k % 2 == 0) ? 32'd0 : 32'd3);

        // Reset while the req2 operation is in EXEC
        do_reset();
        send(1, 16'h3C00, 16'h3C00);
        drain();
        rbase = rlog_id.size();
        send(2, 16'h4400, 16'h4400);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(bus.rsp_valid), 32'd0);
        end
        chk("abort_no_rsp", 32'(rlog_id.size()), 32'(rbase));
        @(posedge clk);
        #1;
        base = glog.size();
        fork
            send(3, 16'h3C00, 16'h3C00);
            send(0, 16'h3C00, 16'h3C00);
        join
        drain();
        chk("abort_ptr_first", 32'(glog[base]), 32'd0);
        chk("abort_ptr_second", 32'(glog[base+1]), 32'd3);
        chk("abort_ids_first", 32'(rlog_id[rbase]), 32'd0);

`ifdef FADD_SCHED_STATS_EN
        do_reset();
        chk("stats_reset", 32'(op_count), 32'd0);
        for (int k = 0; k < 5; k++) begin
            send(k % NREQ, 16'h3C00, 16'h3C00);
            drain();
        end
        chk("stats_five", 32'(op_count), 32'd5);
        force dut.op_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.op_cnt_q;
        send(1, 16'h3C00, 16'h3C00);
        drain();
        chk("stats_wrap", 32'(op_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
